// File: rtl/id_stage_sb.sv
// Decode stage with a built-in destination scoreboard. It resolves branches in ID,
// stalls on RAW hazards, squashes wrong-path slots and registers results into ID/EXE.

module id_stage_sb_cmp #(
   parameter int RA_W = 5
) (
   input  logic            ent_v,
   input  logic [RA_W-1:0] ent_dest,
   input  logic [RA_W-1:0] src1,
   input  logic [RA_W-1:0] src2,
   input  logic            src2_used,
   output logic            hit
);
   // r0 is hardwired, so it can never be a real producer.
   assign hit = ent_v && (ent_dest != '0) &&
                ((ent_dest == src1) || (src2_used && (ent_dest == src2)));
endmodule

module id_stage_sb #(
   parameter int XLEN        = 32,
   parameter int RA_W        = 5,
   parameter int CMD_W       = 5,
   parameter int WB_LATENCY  = 3,
   parameter int FLUSH_SLOTS = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             in_valid,
   input  logic [31:0]      instr,
   input  logic [XLEN-1:0]  reg1,
   input  logic [XLEN-1:0]  reg2,
   input  logic             ctl_wb_en,
   input  logic             ctl_mem_r_en,
   input  logic             ctl_mem_w_en,
   input  logic             ctl_is_imm,
   input  logic             ctl_st_or_bne,
   input  logic             ctl_is_br,
   input  logic             ctl_br_type,
   input  logic             ctl_is_jmp,
   input  logic [CMD_W-1:0] ctl_exe_cmd,
   output logic [RA_W-1:0]  src1,
   output logic [RA_W-1:0]  src2,
   output logic             stall,
   output logic             br_taken,
   output logic             o_valid,
   output logic [RA_W-1:0]  o_dest,
   output logic [XLEN-1:0]  o_val1,
   output logic [XLEN-1:0]  o_val2,
   output logic [XLEN-1:0]  o_reg2,
   output logic [CMD_W-1:0] o_exe_cmd,
   output logic             o_wb_en,
   output logic             o_mem_r_en,
   output logic             o_mem_w_en,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic            v;
      logic [RA_W-1:0] dest;
   } sb_ent_t;

   localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_SLOTS);

   sb_ent_t [WB_LATENCY-1:0] sb_q;
   logic    [WB_LATENCY-1:0] sb_hit;
   logic    [1:0]            sq_cnt;

   logic [RA_W-1:0] dest;
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] val2;
   logic            src2_used;
   logic            squash;
   logic            issue;
   logic            br_cond;
   logic            unused_instr;

   assign unused_instr = ^instr[31:26];

   // ---------------------------------------------------------------- decode
   assign dest      = RA_W'(instr[25:21]);
   assign src1      = RA_W'(instr[20:16]);
   assign src2      = ctl_st_or_bne ? RA_W'(instr[25:21]) : RA_W'(instr[15:11]);
   assign imm_ext   = {{(XLEN-16){instr[15]}}, instr[15:0]};
   assign val2      = ctl_is_imm ? imm_ext : reg2;
   assign src2_used = !ctl_is_imm || ctl_st_or_bne || ctl_is_br;

   // ---------------------------------------------------------------- hazard
   for (genvar k = 0; k < WB_LATENCY; k++) begin : g_cmp
      id_stage_sb_cmp #(.RA_W(RA_W)) u_cmp (
         .ent_v     (sb_q[k].v),
         .ent_dest  (sb_q[k].dest),
         .src1      (src1),
         .src2      (src2),
         .src2_used (src2_used),
         .hit       (sb_hit[k])
      );
   end

   assign squash = (sq_cnt != 2'd0);
   assign stall  = in_valid && !squash && (|sb_hit);
   assign issue  = in_valid && !stall && !squash && !freeze;

   // ---------------------------------------------------------------- branch
   assign br_cond  = ctl_br_type ? (reg1 != reg2) : (reg1 == '0);
   assign br_taken = issue && (ctl_is_jmp || (ctl_is_br && br_cond));

   // The oldest entry drops out on its RF-write cycle; the write-first RF covers it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_q <= '0;
      end else if (!freeze) begin
         for (int k = WB_LATENCY-1; k > 0; k--)
            sb_q[k] <= sb_q[k-1];
         sb_q[0].v    <= issue && ctl_wb_en && (dest != '0);
         sb_q[0].dest <= dest;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sq_cnt <= 2'd0;
      end else if (!freeze) begin
         if (br_taken)
            sq_cnt <= FLUSH_INIT;
         else if (squash && in_valid)
            sq_cnt <= sq_cnt - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall && !freeze && (stall_cnt != '1))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

   // -------------------------------------------------- ID/EXE pipeline reg
   // Bubbles only clear the valid and enables; data fields are don't-care then.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid    <= 1'b0;
         o_dest     <= '0;
         o_val1     <= '0;
         o_val2     <= '0;
         o_reg2     <= '0;
         o_exe_cmd  <= '0;
         o_wb_en    <= 1'b0;
         o_mem_r_en <= 1'b0;
         o_mem_w_en <= 1'b0;
      end else if (!freeze) begin
         if (issue) begin
            o_valid    <= 1'b1;
            o_dest     <= dest;
            o_val1     <= reg1;
            o_val2     <= val2;
            o_reg2     <= reg2;
            o_exe_cmd  <= ctl_exe_cmd;
            o_wb_en    <= ctl_wb_en;
            o_mem_r_en <= ctl_mem_r_en;
            o_mem_w_en <= ctl_mem_w_en;
         end else begin
            o_valid    <= 1'b0;
            o_wb_en    <= 1'b0;
            o_mem_r_en <= 1'b0;
            o_mem_w_en <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_id_stage_sb.sv
// Directed bench for id_stage_sb: hazards, squash, freeze and reset with hand-computed values.

module tb_id_stage_sb;

   localparam int XLEN  = 32;
   localparam int RA_W  = 5;
   localparam int CMD_W = 5;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst, freeze, in_valid;
   logic [31:0]      instr;
   logic [XLEN-1:0]  reg1, reg2;
   logic             ctl_wb_en, ctl_mem_r_en, ctl_mem_w_en, ctl_is_imm;
   logic             ctl_st_or_bne, ctl_is_br, ctl_br_type, ctl_is_jmp;
   logic [CMD_W-1:0] ctl_exe_cmd;
   logic [RA_W-1:0]  src1, src2, o_dest;
   logic             stall, br_taken, o_valid, o_wb_en, o_mem_r_en, o_mem_w_en;
   logic [XLEN-1:0]  o_val1, o_val2, o_reg2;
   logic [CMD_W-1:0] o_exe_cmd;
   logic [CNT_W-1:0] stall_cnt;

   int vectors = 0;
   int errs    = 0;

   id_stage_sb #(.XLEN(XLEN), .RA_W(RA_W), .CMD_W(CMD_W), .WB_LATENCY(3),
                 .FLUSH_SLOTS(1), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .in_valid(in_valid), .instr(instr),
      .reg1(reg1), .reg2(reg2), .ctl_wb_en(ctl_wb_en), .ctl_mem_r_en(ctl_mem_r_en),
      .ctl_mem_w_en(ctl_mem_w_en), .ctl_is_imm(ctl_is_imm), .ctl_st_or_bne(ctl_st_or_bne),
      .ctl_is_br(ctl_is_br), .ctl_br_type(ctl_br_type), .ctl_is_jmp(ctl_is_jmp),
      .ctl_exe_cmd(ctl_exe_cmd), .src1(src1), .src2(src2), .stall(stall),
      .br_taken(br_taken), .o_valid(o_valid), .o_dest(o_dest), .o_val1(o_val1),
      .o_val2(o_val2), .o_reg2(o_reg2), .o_exe_cmd(o_exe_cmd), .o_wb_en(o_wb_en),
      .o_mem_r_en(o_mem_r_en), .o_mem_w_en(o_mem_w_en), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input int d, input int s1, input int rt);
      return {6'd0, 5'(d), 5'(s1), 5'(rt), 11'd0};
   endfunction

   // New instruction with all control decode cleared.
   task automatic put(input logic [31:0] i);
      in_valid      = 1'b1;
      instr         = i;
      ctl_wb_en     = 1'b0;
      ctl_mem_r_en  = 1'b0;
      ctl_mem_w_en  = 1'b0;
      ctl_is_imm    = 1'b0;
      ctl_st_or_bne = 1'b0;
      ctl_is_br     = 1'b0;
      ctl_br_type   = 1'b0;
      ctl_is_jmp    = 1'b0;
      ctl_exe_cmd   = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; freeze = 1'b0; reg1 = '0; reg2 = '0;
      put(32'd0); in_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_dest", o_dest, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_stall", stall, 0);

      // Independent ADD r1 <- r2 + r3
      put(mk(1, 2, 3)); ctl_wb_en = 1'b1; ctl_exe_cmd = 5'd3; reg1 = 32'd10; reg2 = 32'd20;
      #1;
      chk("add_src1", src1, 2);
      chk("add_src2", src2, 3);
      chk("add_stall", stall, 0);
      tick();
      chk("add_o_valid", o_valid, 1);
      chk("add_o_dest", o_dest, 1);
      chk("add_o_val1", o_val1, 10);
      chk("add_o_val2", o_val2, 20);
      chk("add_o_exe_cmd", o_exe_cmd, 3);
      chk("add_o_wb_en", o_wb_en, 1);
      chk("add_stall_cnt", stall_cnt, 0);

      // Producer r4, then a consumer of r4: 3 stall cycles
      put(mk(4, 0, 0)); ctl_wb_en = 1'b1;
      tick();
      chk("p4_o_dest", o_dest, 4);
      put(mk(5, 4, 0)); ctl_wb_en = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("raw_stall", stall, 1);
         tick();
         chk("raw_bubble", o_valid, 0);
      end
      chk("raw_release", stall, 0);
      chk("raw_stall_cnt", stall_cnt, 3);
      tick();
      chk("raw_issue_valid", o_valid, 1);
      chk("raw_issue_dest", o_dest, 5);

      // r0 destination is never tracked
      put(mk(0, 0, 0)); ctl_wb_en = 1'b1;
      tick();
      put(mk(6, 0, 0)); ctl_wb_en = 1'b1;
      #1;
      chk("r0_stall", stall, 0);
      tick();
      chk("r0_o_dest", o_dest, 6);

      // Immediate form ignores a pending rt field
      put(mk(7, 0, 6)); ctl_wb_en = 1'b1; ctl_is_imm = 1'b1;
      #1;
      chk("imm_stall", stall, 0);
      tick();
      chk("imm_o_valid", o_valid, 1);
      chk("imm_o_val2", o_val2, 32'h0000_3000);

      // Store reads dest field as src2: r7 pending -> stall
      put(mk(7, 0, 0)); ctl_st_or_bne = 1'b1; ctl_is_imm = 1'b1; ctl_mem_w_en = 1'b1;
      #1;
      chk("st_src2", src2, 7);
      chk("st_stall", stall, 1);
      tick(); tick(); tick();
      chk("st_release", stall, 0);
      chk("st_stall_cnt", stall_cnt, 6);
      tick();
      chk("st_o_valid", o_valid, 1);
      chk("st_o_mem_w_en", o_mem_w_en, 1);
      chk("st_o_wb_en", o_wb_en, 0);

      // Negative immediate sign extension
      put(mk(8, 0, 31)); ctl_wb_en = 1'b1; ctl_is_imm = 1'b1;
      tick();
      chk("sext_o_val2", o_val2, 32'hFFFF_F800);

      // BEQ not taken / taken, evaluated combinationally without clocking
      put(mk(0, 0, 0)); ctl_is_br = 1'b1; ctl_br_type = 1'b0; reg1 = 32'd3;
      #1;
      chk("beq_nt", br_taken, 0);
      reg1 = 32'd0;
      #1;
      chk("beq_t", br_taken, 1);

      // BNE taken, one slot squashed
      put(mk(9, 10, 0)); ctl_is_br = 1'b1; ctl_br_type = 1'b1; ctl_st_or_bne = 1'b1;
      reg1 = 32'd5; reg2 = 32'd7;
      #1;
      chk("bne_taken", br_taken, 1);
      chk("bne_stall", stall, 0);
      tick();
      chk("bne_o_valid", o_valid, 1);
      put(mk(11, 0, 0)); ctl_wb_en = 1'b1;
      #1;
      chk("sq_br_taken", br_taken, 0);
      chk("sq_stall", stall, 0);
      tick();
      chk("sq_dropped", o_valid, 0);
      put(mk(12, 0, 0)); ctl_wb_en = 1'b1;
      tick();
      chk("post_sq_valid", o_valid, 1);
      chk("post_sq_dest", o_dest, 12);
      put(mk(13, 11, 0)); ctl_wb_en = 1'b1;
      #1;
      chk("sq_no_sb_entry", stall, 0);
      tick();

      // Freeze for 2 cycles during a pending hazard
      put(mk(14, 0, 0)); ctl_wb_en = 1'b1;
      tick();
      put(mk(15, 14, 0)); ctl_wb_en = 1'b1; freeze = 1'b1;
      #1;
      chk("frz_stall", stall, 1);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("frz_stall_hold", stall, 1);
         chk("frz_cnt_hold", stall_cnt, 6);
         chk("frz_o_valid_hold", o_valid, 1);
         chk("frz_o_dest_hold", o_dest, 14);
      end
      freeze = 1'b0;
      tick(); tick();
      chk("frz_still_stall", stall, 1);
      tick();
      chk("frz_release", stall, 0);
      chk("frz_stall_cnt", stall_cnt, 9);
      tick();
      chk("frz_issue_dest", o_dest, 15);
      chk("frz_issue_valid", o_valid, 1);

      // Freeze gates a taken branch; it fires once freeze drops
      put(mk(16, 0, 0)); ctl_is_br = 1'b1; ctl_br_type = 1'b1; ctl_st_or_bne = 1'b1;
      reg1 = 32'd1; reg2 = 32'd2; freeze = 1'b1;
      #1;
      chk("frz_br_gated", br_taken, 0);
      tick();
      freeze = 1'b0;
      #1;
      chk("frz_br_taken", br_taken, 1);
      tick();

      // Reset while squashing with r15 still pending
      put(mk(17, 15, 0)); ctl_wb_en = 1'b1;
      #1;
      chk("pre_rst_stall", stall, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_o_valid", o_valid, 0);
      chk("mid_rst_cnt", stall_cnt, 0);
      tick();
      chk("post_rst_valid", o_valid, 1);
      chk("post_rst_dest", o_dest, 17);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/id_stage_sb.md
Name: id_stage_sb

Overview:
- Parametrised decode stage with a built-in scoreboard, replacing the external Exe/Mem destination compare.
- Decodes the instruction fields and resolves branches in ID.
- Tracks in-flight destination registers in a WB_LATENCY-deep shift register and stalls on RAW hazards.
- Squashes FLUSH_SLOTS fetched instructions after a taken branch, registers all results into the ID/EXE pipeline register, and counts stall cycles.

Parameters:
- XLEN, 32, data width of register values.
- RA_W, 5, register address width.
- CMD_W, 5, EXE command width.
- WB_LATENCY, 3, cycles from issue to register-file write; also the scoreboard depth (>=1).
- FLUSH_SLOTS, 1, accepted instructions squashed after a taken branch (0..3).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  downstream stall; holds all state.
- in_valid  in  1  instruction valid from IF.
- instr  in  32  instruction; dest=[25:21], src1=[20:16], rt=[15:11], imm=[15:0].
- reg1  in  XLEN  RF read of src1.
- reg2  in  XLEN  RF read of src2.
- ctl_wb_en, ctl_mem_r_en, ctl_mem_w_en, ctl_is_imm, ctl_st_or_bne, ctl_is_br, ctl_br_type, ctl_is_jmp  in  1 each  control-unit decode of instr.
- ctl_exe_cmd  in  CMD_W  EXE command.
- src1  out  RA_W  RF read address 1.
- src2  out  RA_W  RF read address 2.
- stall  out  1  hazard detected; IF must hold the PC.
- br_taken  out  1  branch/jump taken.
- o_valid  out  1  pipeline-register fields are valid.
- o_dest  out  RA_W  registered field.
- o_val1  out  XLEN  registered field.
- o_val2  out  XLEN  registered field.
- o_reg2  out  XLEN  registered field.
- o_exe_cmd  out  CMD_W  registered field.
- o_wb_en, o_mem_r_en, o_mem_w_en  out  1 each  registered fields.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Address decode:
  - src1 = instr[20:16].
  - src2 = ctl_st_or_bne ? instr[25:21] : instr[15:11].
  - val2 = ctl_is_imm ? sign-extended imm : reg2.
- src2 is "used" when !ctl_is_imm, or ctl_st_or_bne, or ctl_is_br.
- Scoreboard:
  - WB_LATENCY entries {v, dest}; entry k holds the instruction issued k+1 cycles ago.
  - Each non-frozen cycle: shift by one; entry 0 <= {issue & ctl_wb_en & dest!=0, dest}.
  - The oldest entry falls off at its RF-write cycle. RF is write-first, so no hazard against the falling entry.
- Hazard, combinational:
  - stall = in_valid & !squash & any valid entry k with dest == src1, or with dest == src2 when src2 is used.
  - Address 0 never matches.
- Issue:
  - issue = in_valid & !stall & !squash & !freeze.
  - On issue, the pipeline register loads all fields and o_valid <= 1.
  - On !issue & !freeze, o_valid <= 0 and control enables are cleared (bubble).
  - On freeze, everything holds, including the scoreboard.
- Branch:
  - br_taken = issue & (ctl_is_jmp | (ctl_is_br & cond)).
  - cond: br_type 0 = (reg1==0); 1 = (reg1!=reg2).
  - A branch never issues while stalled.
- Squash:
  - On br_taken, sq_cnt <= FLUSH_SLOTS.
  - squash = sq_cnt != 0.
  - While squash & in_valid & !freeze, sq_cnt decrements and the instruction is dropped (bubble out, no scoreboard entry).
- stall_cnt increments on each cycle with stall & !freeze and saturates at all-ones.
- Reset (rst=1 at clk edge):
  - All scoreboard v=0, sq_cnt=0, stall_cnt=0.
  - o_valid=0, all o_* = 0.
  - Reset mid-stall or mid-squash aborts both.
- Simultaneous freeze & br condition: no br_taken (issue gated); re-evaluated the next cycle.

Test Plan:
- Reset, then an independent ADD r1<-r2+r3 with in_valid=1 → next cycle o_valid=1, o_dest=1, stall never asserted, stall_cnt=0.
- WB_LATENCY=3: issue dest=4, then an instruction reading src1=4 → stall=1 for exactly 3 cycles, issues on the 4th; stall_cnt=3, with bubbles on o_valid meanwhile.
- Issue dest=0 with wb_en, then read r0 → no stall.
- Issue imm instruction with instr[15:11] = a pending dest → no stall. Same with ctl_st_or_bne=1 and rt pending → stall.
- BNE reg1=5, reg2=7, FLUSH_SLOTS=1 → br_taken=1 for one cycle; next valid instr dropped (o_valid=0); following instr issues.
- freeze=1 for 2 cycles during a pending hazard → scoreboard, o_*, stall_cnt hold; stall released 2 cycles later than without freeze.
- rst asserted mid-stall with sq_cnt=1 → next cycle stall=0, o_valid=0, stall_cnt=0, the next instr issues.
